// File: rtl/axi_cut_pkg.sv
// Shared AXI4 channel and request/response typedefs for this codebase slice.
// axi_cut takes its types as parameters; these are the defaults used when a
// caller does not override them.
// Optional build macro: AXI_CUT_PROTOCOL_CHECK_EN (see axi_cut_spill_reg.sv).
package axi_cut_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    // Write address channel
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } aw_chan_t;

    // Write data channel
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    // Write response channel
    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    // Read address channel
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_chan_t;

    // Read data channel
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    // Master-to-slave bundle
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    // Slave-to-master bundle
    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// File: rtl/axi_cut_spill_reg.sv
// Generic 2-entry spill register for one valid/ready channel.
// Entry a is always the head; entry b only fills when the output stalls while
// a is occupied. ready_o and valid_o come straight from flops, so no
// combinational path exists between the two sides.
// Optional build macro: AXI_CUT_PROTOCOL_CHECK_EN compiles in input-side
// handshake stability and occupancy assertions (simulation only).
module axi_cut_spill_reg #(
    parameter type T      = logic,
    parameter bit  Bypass = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (Bypass) begin : g_bypass

        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;

    end else begin : g_spill

        T     a_data_q, b_data_q;
        logic a_full_q, b_full_q;
        logic push, pop;

        // Handshakes on each side; ready_o is low whenever b is occupied.
        assign push    = valid_i & ready_o;
        assign pop     = valid_o & ready_i;
        assign ready_o = ~b_full_q;
        assign valid_o = a_full_q;
        assign data_o  = a_data_q;

        // Occupancy and payload update; b is only refilled from the input and
        // only drained into a, which keeps strict FIFO order.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_data_q <= '0;
                b_data_q <= '0;
                a_full_q <= 1'b0;
                b_full_q <= 1'b0;
            end else if (pop) begin
                if (b_full_q) begin
                    // Full: the input is not ready this cycle, so no push here.
                    a_data_q <= b_data_q;
                    b_full_q <= 1'b0;
                end else if (push) begin
                    a_data_q <= data_i;
                end else begin
                    a_full_q <= 1'b0;
                end
            end else if (push) begin
                if (a_full_q) begin
                    b_data_q <= data_i;
                    b_full_q <= 1'b1;
                end else begin
                    a_data_q <= data_i;
                    a_full_q <= 1'b1;
                end
            end
        end

`ifdef AXI_CUT_PROTOCOL_CHECK_EN
        // Upstream must keep valid and payload stable until accepted.
        assert property (@(posedge clk_i) disable iff (rst_i)
                         (valid_i && !ready_o) |=> (valid_i && $stable(data_i)))
        else $error("axi_cut_spill_reg: input dropped valid or changed payload while stalled");

        // b may only hold a beat behind an occupied a (occupancy never above 2).
        assert property (@(posedge clk_i) disable iff (rst_i)
                         !(b_full_q && !a_full_q))
        else $error("axi_cut_spill_reg: occupancy invariant broken");
`endif

    end

endmodule

// File: rtl/axi_cut.sv
// AXI4 / AXI4-Lite register slice: one independent spill register per channel.
// Forward channels (AW, W, AR) flow slave port -> master port, reverse
// channels (B, R) flow master port -> slave port. With Bypass set every
// channel collapses to wires.
// Optional build macro: AXI_CUT_PROTOCOL_CHECK_EN (per-channel assertions).
module axi_cut
    import axi_cut_pkg::*;
#(
    parameter bit  Bypass    = 1'b0,
    parameter type aw_chan_t = axi_cut_pkg::aw_chan_t,
    parameter type w_chan_t  = axi_cut_pkg::w_chan_t,
    parameter type b_chan_t  = axi_cut_pkg::b_chan_t,
    parameter type ar_chan_t = axi_cut_pkg::ar_chan_t,
    parameter type r_chan_t  = axi_cut_pkg::r_chan_t,
    parameter type req_t     = axi_cut_pkg::req_t,
    parameter type resp_t    = axi_cut_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    aw_chan_t aw_data;
    w_chan_t  w_data;
    b_chan_t  b_data;
    ar_chan_t ar_data;
    r_chan_t  r_data;
    logic     aw_valid, aw_ready;
    logic     w_valid, w_ready;
    logic     b_valid, b_ready;
    logic     ar_valid, ar_ready;
    logic     r_valid, r_ready;

    axi_cut_spill_reg #(
        .T      (aw_chan_t),
        .Bypass (Bypass)
    ) i_aw_cut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.aw_valid),
        .ready_o (aw_ready),
        .data_i  (slv_req_i.aw),
        .valid_o (aw_valid),
        .ready_i (mst_resp_i.aw_ready),
        .data_o  (aw_data)
    );

    axi_cut_spill_reg #(
        .T      (w_chan_t),
        .Bypass (Bypass)
    ) i_w_cut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.w_valid),
        .ready_o (w_ready),
        .data_i  (slv_req_i.w),
        .valid_o (w_valid),
        .ready_i (mst_resp_i.w_ready),
        .data_o  (w_data)
    );

    axi_cut_spill_reg #(
        .T      (b_chan_t),
        .Bypass (Bypass)
    ) i_b_cut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mst_resp_i.b_valid),
        .ready_o (b_ready),
        .data_i  (mst_resp_i.b),
        .valid_o (b_valid),
        .ready_i (slv_req_i.b_ready),
        .data_o  (b_data)
    );

    axi_cut_spill_reg #(
        .T      (ar_chan_t),
        .Bypass (Bypass)
    ) i_ar_cut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (slv_req_i.ar_valid),
        .ready_o (ar_ready),
        .data_i  (slv_req_i.ar),
        .valid_o (ar_valid),
        .ready_i (mst_resp_i.ar_ready),
        .data_o  (ar_data)
    );

    axi_cut_spill_reg #(
        .T      (r_chan_t),
        .Bypass (Bypass)
    ) i_r_cut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mst_resp_i.r_valid),
        .ready_o (r_ready),
        .data_i  (mst_resp_i.r),
        .valid_o (r_valid),
        .ready_i (slv_req_i.r_ready),
        .data_o  (r_data)
    );

    // Downstream request bundle: forward payloads plus reverse-channel readies.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_data;
        mst_req_o.aw_valid = aw_valid;
        mst_req_o.w        = w_data;
        mst_req_o.w_valid  = w_valid;
        mst_req_o.b_ready  = b_ready;
        mst_req_o.ar       = ar_data;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.r_ready  = r_ready;
    end

    // Upstream response bundle: forward-channel readies plus reverse payloads.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.b        = b_data;
        slv_resp_o.r_valid  = r_valid;
        slv_resp_o.r        = r_data;
    end

endmodule

// File: tb/tb_axi_cut.sv
// Self-checking bench for axi_cut: directed scenarios plus randomized traffic
// checked against a per-channel bounded-queue reference model.
module tb_axi_cut;
    import axi_cut_pkg::*;

    logic  clk_i;
    logic  rst_i;
    req_t  slv_req, mst_req;
    resp_t slv_resp, mst_resp;
    req_t  byp_slv_req, byp_mst_req;
    resp_t byp_slv_resp, byp_mst_resp;

    int n_vec;
    int n_err;

    // Reference model: each channel is an ordered buffer holding at most two beats.
    aw_chan_t aw_q[$];
    w_chan_t  w_q[$];
    b_chan_t  b_q[$];
    ar_chan_t ar_q[$];
    r_chan_t  r_q[$];

    axi_cut #(.Bypass(1'b0)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    axi_cut #(.Bypass(1'b1)) dut_byp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slv_req_i  (byp_slv_req),
        .slv_resp_o (byp_slv_resp),
        .mst_req_o  (byp_mst_req),
        .mst_resp_i (byp_mst_resp)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Model update: a beat leaves when the buffer is non-empty and the sink is
    // ready; a beat enters when offered and the buffer held fewer than two.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_q.delete(); w_q.delete(); b_q.delete(); ar_q.delete(); r_q.delete();
        end else begin : upd
            bit pop, push;
            pop = aw_q.size() > 0 && mst_resp.aw_ready; push = slv_req.aw_valid && aw_q.size() < 2;
            if (pop) void'(aw_q.pop_front());
            if (push) aw_q.push_back(slv_req.aw);
            pop = w_q.size() > 0 && mst_resp.w_ready; push = slv_req.w_valid && w_q.size() < 2;
            if (pop) void'(w_q.pop_front());
            if (push) w_q.push_back(slv_req.w);
            pop = b_q.size() > 0 && slv_req.b_ready; push = mst_resp.b_valid && b_q.size() < 2;
            if (pop) void'(b_q.pop_front());
            if (push) b_q.push_back(mst_resp.b);
            pop = ar_q.size() > 0 && mst_resp.ar_ready; push = slv_req.ar_valid && ar_q.size() < 2;
            if (pop) void'(ar_q.pop_front());
            if (push) ar_q.push_back(slv_req.ar);
            pop = r_q.size() > 0 && slv_req.r_ready; push = mst_resp.r_valid && r_q.size() < 2;
            if (pop) void'(r_q.pop_front());
            if (push) r_q.push_back(mst_resp.r);
        end
    end

    task automatic idle_inputs();
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        // State straight out of the power-on reset
        n_vec++; if ({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                      slv_resp.b_valid, slv_resp.r_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_valids: got %b required 00000",
                {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                 slv_resp.b_valid, slv_resp.r_valid});
        end
        n_vec++; if ({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                      mst_req.b_ready, mst_req.r_ready} !== 5'b11111) begin
            n_err++; $display("FAIL reset_readys: got %b required 11111",
                {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                 mst_req.b_ready, mst_req.r_ready});
        end
        n_vec++; if (mst_req.aw !== '0) begin
            n_err++; $display("FAIL reset_aw_payload: got %h required 0", mst_req.aw);
        end
        // Load beats with stalled sinks, then reset mid-cycle
        mst_resp.aw_ready = 1'b0; mst_resp.w_ready = 1'b0; slv_req.r_ready = 1'b0;
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h55;
        slv_req.w_valid  = 1'b1; slv_req.w.data  = 32'h66;
        mst_resp.r_valid = 1'b1; mst_resp.r.data = 32'h77;
        next_cycle();
        next_cycle();
        n_vec++; if (slv_resp.aw_ready !== 1'b0) begin
            n_err++; $display("FAIL prereset_aw_full: ready got %b required 0", slv_resp.aw_ready);
        end
        #2 rst_i = 1'b1;
        #1;
        n_vec++; if ({mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                      slv_resp.b_valid, slv_resp.r_valid} !== 5'b0) begin
            n_err++; $display("FAIL midreset_valids: got %b required 00000",
                {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                 slv_resp.b_valid, slv_resp.r_valid});
        end
        n_vec++; if ({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                      mst_req.b_ready, mst_req.r_ready} !== 5'b11111) begin
            n_err++; $display("FAIL midreset_readys: got %b required 11111",
                {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                 mst_req.b_ready, mst_req.r_ready});
        end
        n_vec++; if (mst_req.w !== '0) begin
            n_err++; $display("FAIL midreset_w_payload: got %h required 0", mst_req.w);
        end
        idle_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        next_cycle();
        // Buffered beats must not reappear after reset
        n_vec++; if ({mst_req.aw_valid, mst_req.w_valid, slv_resp.r_valid} !== 3'b0) begin
            n_err++; $display("FAIL postreset_dropped: got %b required 000",
                {mst_req.aw_valid, mst_req.w_valid, slv_resp.r_valid});
        end
    endtask

    task automatic test_single_beat();
        idle_inputs();
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h1000; slv_req.aw.id = 4'd3;
        @(negedge clk_i);
        n_vec++; if (mst_req.aw_valid !== 1'b0) begin
            n_err++; $display("FAIL single_no_bypass: valid got %b required 0", mst_req.aw_valid);
        end
        next_cycle();
        slv_req.aw_valid = 1'b0;
        @(negedge clk_i);
        n_vec++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.addr !== 32'h1000
                     || mst_req.aw.id !== 4'd3) begin
            n_err++; $display("FAIL single_beat: got v=%b addr=%h id=%0d required v=1 addr=1000 id=3",
                mst_req.aw_valid, mst_req.aw.addr, mst_req.aw.id);
        end
        next_cycle();
        @(negedge clk_i);
        n_vec++; if (mst_req.aw_valid !== 1'b0) begin
            n_err++; $display("FAIL single_once: valid got %b required 0", mst_req.aw_valid);
        end
        next_cycle();
    endtask

    task automatic test_back_pressure();
        logic [31:0] vals[3];
        logic [31:0] got[$];
        int idx;
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        idle_inputs();
        mst_resp.w_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) begin
                n_vec++; if (idx != 2 || slv_resp.w_ready !== 1'b0) begin
                    n_err++; $display("FAIL bp_stall: accepted %0d ready %b required 2 and 0",
                        idx, slv_resp.w_ready);
                end
                mst_resp.w_ready = 1'b1;
            end
            slv_req.w_valid = (idx < 3);
            slv_req.w.data  = (idx < 3) ? vals[idx] : 32'h0;
            slv_req.w.strb  = 4'hF;
            slv_req.w.last  = 1'b1;
            @(negedge clk_i);
            if (mst_req.w_valid && mst_resp.w_ready) got.push_back(mst_req.w.data);
            if (slv_req.w_valid && slv_resp.w_ready) idx++;
            next_cycle();
        end
        n_vec++; if (got.size() != 3) begin
            n_err++; $display("FAIL bp_count: got %0d beats required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_vec++; if (got[i] !== vals[i]) begin
                n_err++; $display("FAIL bp_order[%0d]: got %h required %h", i, got[i], vals[i]);
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_streaming();
        idle_inputs();
        for (int i = 0; i <= 17; i++) begin
            mst_resp.r_valid  = (i < 16);
            mst_resp.r.data   = 32'(i);
            mst_resp.r.id     = 4'd1;
            @(negedge clk_i);
            n_vec++; if (slv_resp.r_valid !== (i >= 1 && i <= 16)) begin
                n_err++; $display("FAIL stream_valid[%0d]: got %b required %b",
                    i, slv_resp.r_valid, (i >= 1 && i <= 16));
            end
            if (i >= 1 && i <= 16) begin
                n_vec++; if (slv_resp.r.data !== 32'(i - 1) || mst_req.r_ready !== 1'b1) begin
                    n_err++; $display("FAIL stream_data[%0d]: got %0d ready %b required %0d ready 1",
                        i, slv_resp.r.data, mst_req.r_ready, i - 1);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_independence();
        idle_inputs();
        slv_req.b_ready  = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd5; mst_resp.b.resp = RespOkay;
        next_cycle();
        mst_resp.b_valid = 1'b0; mst_resp.b = '0;
        for (int i = 0; i <= 9; i++) begin
            slv_req.ar_valid = (i < 8);
            slv_req.ar.addr  = 32'h100 + 32'(i) * 4;
            @(negedge clk_i);
            n_vec++; if (mst_req.ar_valid !== (i >= 1 && i <= 8) || slv_resp.ar_ready !== 1'b1) begin
                n_err++; $display("FAIL indep_ar_flow[%0d]: got v=%b rdy=%b required v=%b rdy=1",
                    i, mst_req.ar_valid, slv_resp.ar_ready, (i >= 1 && i <= 8));
            end
            if (i >= 1 && i <= 8) begin
                n_vec++; if (mst_req.ar.addr !== 32'h100 + 32'(i - 1) * 4) begin
                    n_err++; $display("FAIL indep_ar_addr[%0d]: got %h required %h",
                        i, mst_req.ar.addr, 32'h100 + 32'(i - 1) * 4);
                end
            end
            n_vec++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd5
                         || slv_resp.b.resp !== RespOkay) begin
                n_err++; $display("FAIL indep_b_hold[%0d]: got v=%b id=%0d resp=%0d required 1/5/0",
                    i, slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp);
            end
            next_cycle();
        end
        slv_req.b_ready = 1'b1;
        next_cycle();
        @(negedge clk_i);
        n_vec++; if (slv_resp.b_valid !== 1'b0) begin
            n_err++; $display("FAIL indep_b_drain: valid got %b required 0", slv_resp.b_valid);
        end
        next_cycle();
    endtask

    task automatic test_random(input int cycles);
        logic [63:0] rnd;
        bit aw_h, w_h, b_h, ar_h, r_h;
        aw_h = 0; w_h = 0; b_h = 0; ar_h = 0; r_h = 0;
        idle_inputs();
        for (int c = 0; c < cycles; c++) begin
            // Offered beats stay unchanged until the model says they were taken
            if (!aw_h) begin rnd = {$urandom, $urandom};
                slv_req.aw = rnd[$bits(aw_chan_t)-1:0]; slv_req.aw_valid = 1'($urandom_range(0, 1)); end
            if (!w_h) begin rnd = {$urandom, $urandom};
                slv_req.w = rnd[$bits(w_chan_t)-1:0]; slv_req.w_valid = 1'($urandom_range(0, 1)); end
            if (!b_h) begin rnd = {$urandom, $urandom};
                mst_resp.b = rnd[$bits(b_chan_t)-1:0]; mst_resp.b_valid = 1'($urandom_range(0, 1)); end
            if (!ar_h) begin rnd = {$urandom, $urandom};
                slv_req.ar = rnd[$bits(ar_chan_t)-1:0]; slv_req.ar_valid = 1'($urandom_range(0, 1)); end
            if (!r_h) begin rnd = {$urandom, $urandom};
                mst_resp.r = rnd[$bits(r_chan_t)-1:0]; mst_resp.r_valid = 1'($urandom_range(0, 1)); end
            mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
            mst_resp.w_ready  = ($urandom_range(0, 3) != 0);
            slv_req.b_ready   = ($urandom_range(0, 2) != 0);
            mst_resp.ar_ready = ($urandom_range(0, 1) != 0);
            slv_req.r_ready   = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            n_vec++; if (mst_req.aw_valid !== (aw_q.size() > 0) || slv_resp.aw_ready !== (aw_q.size() < 2)) begin
                n_err++; $display("FAIL rnd_aw_hs[%0d]: got v=%b r=%b required occupancy %0d",
                    c, mst_req.aw_valid, slv_resp.aw_ready, aw_q.size()); end
            if (aw_q.size() > 0) begin n_vec++; if (mst_req.aw !== aw_q[0]) begin
                n_err++; $display("FAIL rnd_aw_data[%0d]: got %h required %h", c, mst_req.aw, aw_q[0]); end end
            n_vec++; if (mst_req.w_valid !== (w_q.size() > 0) || slv_resp.w_ready !== (w_q.size() < 2)) begin
                n_err++; $display("FAIL rnd_w_hs[%0d]: got v=%b r=%b required occupancy %0d",
                    c, mst_req.w_valid, slv_resp.w_ready, w_q.size()); end
            if (w_q.size() > 0) begin n_vec++; if (mst_req.w !== w_q[0]) begin
                n_err++; $display("FAIL rnd_w_data[%0d]: got %h required %h", c, mst_req.w, w_q[0]); end end
            n_vec++; if (slv_resp.b_valid !== (b_q.size() > 0) || mst_req.b_ready !== (b_q.size() < 2)) begin
                n_err++; $display("FAIL rnd_b_hs[%0d]: got v=%b r=%b required occupancy %0d",
                    c, slv_resp.b_valid, mst_req.b_ready, b_q.size()); end
            if (b_q.size() > 0) begin n_vec++; if (slv_resp.b !== b_q[0]) begin
                n_err++; $display("FAIL rnd_b_data[%0d]: got %h required %h", c, slv_resp.b, b_q[0]); end end
            n_vec++; if (mst_req.ar_valid !== (ar_q.size() > 0) || slv_resp.ar_ready !== (ar_q.size() < 2)) begin
                n_err++; $display("FAIL rnd_ar_hs[%0d]: got v=%b r=%b required occupancy %0d",
                    c, mst_req.ar_valid, slv_resp.ar_ready, ar_q.size()); end
            if (ar_q.size() > 0) begin n_vec++; if (mst_req.ar !== ar_q[0]) begin
                n_err++; $display("FAIL rnd_ar_data[%0d]: got %h required %h", c, mst_req.ar, ar_q[0]); end end
            n_vec++; if (slv_resp.r_valid !== (r_q.size() > 0) || mst_req.r_ready !== (r_q.size() < 2)) begin
                n_err++; $display("FAIL rnd_r_hs[%0d]: got v=%b r=%b required occupancy %0d",
                    c, slv_resp.r_valid, mst_req.r_ready, r_q.size()); end
            if (r_q.size() > 0) begin n_vec++; if (slv_resp.r !== r_q[0]) begin
                n_err++; $display("FAIL rnd_r_data[%0d]: got %h required %h", c, slv_resp.r, r_q[0]); end end
            aw_h = slv_req.aw_valid && aw_q.size() >= 2;
            w_h  = slv_req.w_valid  && w_q.size()  >= 2;
            b_h  = mst_resp.b_valid && b_q.size()  >= 2;
            ar_h = slv_req.ar_valid && ar_q.size() >= 2;
            r_h  = mst_resp.r_valid && r_q.size()  >= 2;
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();
    endtask

    task automatic test_bypass();
        logic [159:0] big;
        req_t  exp_req;
        resp_t exp_resp;
        for (int i = 0; i < 16; i++) begin
            big = {$urandom, $urandom, $urandom, $urandom, $urandom};
            byp_slv_req = big[$bits(req_t)-1:0];
            exp_req     = byp_slv_req;
            big = {$urandom, $urandom, $urandom, $urandom, $urandom};
            byp_mst_resp = big[$bits(resp_t)-1:0];
            exp_resp     = byp_mst_resp;
            rst_i = (i % 4 == 3);
            #1;
            n_vec++; if (byp_mst_req !== exp_req) begin
                n_err++; $display("FAIL bypass_req[%0d]: got %h required %h", i, byp_mst_req, exp_req);
            end
            n_vec++; if (byp_slv_resp !== exp_resp) begin
                n_err++; $display("FAIL bypass_resp[%0d]: got %h required %h", i, byp_slv_resp, exp_resp);
            end
            #2;
        end
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b1;
        idle_inputs();
        byp_slv_req  = '0;
        byp_mst_resp = '0;
        #12 rst_i = 1'b0;
        next_cycle();
        test_reset();
        test_single_beat();
        test_back_pressure();
        test_streaming();
        test_independence();
        test_random(400);
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
